ram_arbiter: RTL and testbench

//  Shares the single ram instance between instruction fetch (cpu pc/ir path) and datapath load/store.
//  One RAM access per cycle; fixed priority data > fetch with anti-starvation boost for fetch.

---
 rtl/ram_arb_pkg.sv | 14 +
 rtl/ram_arb_pick.sv | 25 ++
 rtl/ram_arbiter.sv | 128 ++++++++++++
 tb/tb_ram_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types and sizes for the single-port RAM arbiter
package ram_arb_pkg;

  localparam int RAM_AW = 8;
  localparam int RAM_DW = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2,
    OWN_DBG  = 2'd3
  } owner_t;

endpackage

// File: rtl/ram_arb_pick.sv
// rtl/ram_arb_pick.sv - combinational priority picker: debug > boosted fetch > data > fetch
module ram_arb_pick (
  input  logic dbg_req,
  input  logic d_req,
  input  logic if_req,
  input  logic boost,
  output logic dbg_gnt,
  output logic d_gnt,
  output logic if_gnt
);

  always_comb begin
    dbg_gnt = 1'b0;
    d_gnt   = 1'b0;
    if_gnt  = 1'b0;
    if (dbg_req) begin
      dbg_gnt = 1'b1;
    end else if (if_req && (boost || !d_req)) begin
      if_gnt = 1'b1;
    end else if (d_req) begin
      d_gnt = 1'b1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - shares one RAM between fetch and data load/store, 1-cycle read latency
// Optional debug requester with absolute priority when RAM_ARB_DBG_PORT_EN is defined.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW           = RAM_AW,
  parameter int DW           = RAM_DW,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] rdata,
  output logic          ram_w_en,
  output logic [AW-1:0] ram_r_addr,
  output logic [AW-1:0] ram_w_addr,
  output logic [DW-1:0] ram_w_data,
`ifdef RAM_ARB_DBG_PORT_EN
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
`endif
  input  logic [DW-1:0] ram_r_data
);

  logic [3:0] starve_cnt_q, starve_cnt_d;
  owner_t     rd_owner_q, rd_owner_d;

  logic          dbg_req_i, dbg_we_i, dbg_gnt_i, d_gnt_i, if_gnt_i, boost;
  logic [AW-1:0] dbg_addr_i;
  logic [DW-1:0] dbg_wdata_i;

`ifdef RAM_ARB_DBG_PORT_EN
  assign dbg_req_i   = dbg_req;
  assign dbg_we_i    = dbg_we;
  assign dbg_addr_i  = dbg_addr;
  assign dbg_wdata_i = dbg_wdata;
  assign dbg_gnt     = dbg_gnt_i;
  assign dbg_rvalid  = (rd_owner_q == OWN_DBG);
`else
  assign dbg_req_i   = 1'b0;
  assign dbg_we_i    = 1'b0;
  assign dbg_addr_i  = '0;
  assign dbg_wdata_i = '0;
`endif

  assign boost = (starve_cnt_q == 4'(STARVE_LIMIT));

  // Requests are masked while in reset so no grant can leak out asynchronously.
  ram_arb_pick u_pick (
    .dbg_req (dbg_req_i && rst_n),
    .d_req   (d_req && rst_n),
    .if_req  (if_req && rst_n),
    .boost   (boost),
    .dbg_gnt (dbg_gnt_i),
    .d_gnt   (d_gnt_i),
    .if_gnt  (if_gnt_i)
  );

  assign if_gnt = if_gnt_i;
  assign d_gnt  = d_gnt_i;

  always_comb begin
    ram_w_en     = 1'b0;
    ram_r_addr   = '0;
    ram_w_addr   = '0;
    ram_w_data   = '0;
    rd_owner_d   = OWN_NONE;
    starve_cnt_d = starve_cnt_q;

    if (dbg_gnt_i) begin
      if (dbg_we_i) begin
        ram_w_en   = 1'b1;
        ram_w_addr = dbg_addr_i;
        ram_w_data = dbg_wdata_i;
      end else begin
        ram_r_addr = dbg_addr_i;
        rd_owner_d = OWN_DBG;
      end
    end else if (d_gnt_i) begin
      if (d_we) begin
        ram_w_en   = 1'b1;
        ram_w_addr = d_addr;
        ram_w_data = d_wdata;
      end else begin
        ram_r_addr = d_addr;
        rd_owner_d = OWN_D;
      end
    end else if (if_gnt_i) begin
      ram_r_addr = if_addr;
      rd_owner_d = OWN_IF;
    end

    // Any cycle fetch asks and loses (to data or debug) counts toward the boost.
    if (!if_req || if_gnt_i) begin
      starve_cnt_d = 4'd0;
    end else if (!boost) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= 4'd0;
      rd_owner_q   <= OWN_NONE;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  assign if_rvalid = (rd_owner_q == OWN_IF);
  assign d_rvalid  = (rd_owner_q == OWN_D);
  assign rdata     = ram_r_data;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - randomized self-checking bench for ram_arbiter against a behavioural model
module tb_ram_arbiter;

  localparam int AW    = 8;
  localparam int DW    = 16;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, rdata;
  logic          ram_w_en;
  logic [AW-1:0] ram_r_addr, ram_w_addr;
  logic [DW-1:0] ram_w_data, ram_r_data;
`ifdef RAM_ARB_DBG_PORT_EN
  logic          dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
`endif

  always #5 clk = ~clk;

  ram_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .rdata      (rdata),
    .ram_w_en   (ram_w_en),
    .ram_r_addr (ram_r_addr),
    .ram_w_addr (ram_w_addr),
    .ram_w_data (ram_w_data),
`ifdef RAM_ARB_DBG_PORT_EN
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_gnt    (dbg_gnt),
    .dbg_rvalid (dbg_rvalid),
`endif
    .ram_r_data (ram_r_data)
  );

  function automatic logic [DW-1:0] init_val(input int a);
    return DW'((a * 16'h0101) ^ 16'h5A3C);
  endfunction

  // Environment RAM: registered read, reloaded with a known pattern while in reset.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else if (ram_w_en) begin
      mem[ram_w_addr] <= ram_w_data;
    end
    ram_r_data <= mem[ram_r_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural model: shadow memory plus count of consecutive lost fetch cycles.
  logic [DW-1:0] shadow [256];
  int denied;
  logic obs_if_gnt, obs_d_gnt, obs_dbg_gnt;

  task automatic model_reset();
    denied = 0;
    for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
  endtask

  // who: 0 none, 1 fetch, 2 data, 3 debug
  task automatic step();
    logic e_if, e_d, e_dbg, wr, rd;
    int who, raddr, waddr;
    logic [DW-1:0] wdat;
    #1;
    e_dbg = 1'b0;
`ifdef RAM_ARB_DBG_PORT_EN
    e_dbg = dbg_req;
`endif
    e_if = !e_dbg && if_req && (!d_req || denied >= LIMIT);
    e_d  = !e_dbg && !e_if && d_req;
    obs_if_gnt = if_gnt;
    obs_d_gnt  = d_gnt;
    obs_dbg_gnt = 1'b0;
`ifdef RAM_ARB_DBG_PORT_EN
    obs_dbg_gnt = dbg_gnt;
    check_eq("dbg_gnt", dbg_gnt, e_dbg);
`endif
    check_eq("if_gnt", if_gnt, e_if);
    check_eq("d_gnt", d_gnt, e_d);

    wr = 0; rd = 0; who = 0; raddr = 0; waddr = 0; wdat = '0;
    if (e_if) begin
      rd = 1; who = 1; raddr = int'(if_addr);
    end else if (e_d) begin
      if (d_we) begin wr = 1; waddr = int'(d_addr); wdat = d_wdata; end
      else begin rd = 1; who = 2; raddr = int'(d_addr); end
    end
`ifdef RAM_ARB_DBG_PORT_EN
    if (e_dbg) begin
      if (dbg_we) begin wr = 1; waddr = int'(dbg_addr); wdat = dbg_wdata; end
      else begin rd = 1; who = 3; raddr = int'(dbg_addr); end
    end
`endif
    check_eq("ram_w_en", ram_w_en, wr);
    if (wr) begin
      check_eq("ram_w_addr", ram_w_addr, waddr);
      check_eq("ram_w_data", ram_w_data, wdat);
    end
    if (rd) check_eq("ram_r_addr", ram_r_addr, raddr);
    if (!wr && !rd) begin
      check_eq("idle_r_addr", ram_r_addr, 0);
      check_eq("idle_w_addr", ram_w_addr, 0);
      check_eq("idle_w_data", ram_w_data, 0);
    end

    if (if_req && !e_if) denied = (denied + 1 > LIMIT) ? LIMIT : denied + 1;
    else denied = 0;

    @(posedge clk);
    #1;
    check_eq("if_rvalid", if_rvalid, who == 1);
    check_eq("d_rvalid", d_rvalid, who == 2);
`ifdef RAM_ARB_DBG_PORT_EN
    check_eq("dbg_rvalid", dbg_rvalid, who == 3);
`endif
    if (rd) check_eq("rdata", rdata, shadow[raddr]);
    if (wr) shadow[waddr] = wdat;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
`ifdef RAM_ARB_DBG_PORT_EN
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
`endif
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    if_req = 1; d_req = 1; d_we = 1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_if_gnt", if_gnt, 0);
    check_eq("rst_d_gnt", d_gnt, 0);
    check_eq("rst_w_en", ram_w_en, 0);
    check_eq("rst_if_rvalid", if_rvalid, 0);
    check_eq("rst_d_rvalid", d_rvalid, 0);
    idle_inputs();
    rst_n = 1'b1;

    // write then fetch the same address on the next cycle
    d_req = 1; d_we = 1; d_addr = 8'h10; d_wdata = 16'hBEEF;
    step();
    idle_inputs();
    if_req = 1; if_addr = 8'h10;
    step();
    check_eq("wr_rd_rvalid", if_rvalid, 1);
    check_eq("wr_rd_rdata", rdata, 16'hBEEF);

    // back-to-back fetches, no bubble
    for (int i = 0; i < 3; i++) begin
      if_req = 1; if_addr = AW'(i);
      step();
      check_eq("b2b_rvalid", if_rvalid, 1);
      check_eq("b2b_rdata", rdata, init_val(i));
    end
    idle_inputs();
    step();

    // both held: data wins LIMIT cycles, then one fetch
    if_req = 1; if_addr = 8'h05; d_req = 1; d_we = 0; d_addr = 8'h06;
    for (int i = 0; i < 2 * (LIMIT + 1); i++) begin
      step();
      check_eq("boost_pattern", obs_if_gnt, (i % (LIMIT + 1)) == LIMIT);
    end
    idle_inputs();
    step();

    // data read rvalid exactly once, never after a write
    d_req = 1; d_we = 0; d_addr = 8'h20;
    step();
    check_eq("d_rd_rvalid", d_rvalid, 1);
    idle_inputs();
    step();
    check_eq("d_rd_one_shot", d_rvalid, 0);
    d_req = 1; d_we = 1; d_addr = 8'h21; d_wdata = 16'h1234;
    step();
    check_eq("d_wr_no_rvalid", d_rvalid, 0);
    idle_inputs();

`ifdef RAM_ARB_DBG_PORT_EN
    step();
    if_req = 1; if_addr = 8'h07; d_req = 1; d_we = 0; d_addr = 8'h08;
    repeat (LIMIT) step();
    dbg_req = 1; dbg_we = 0; dbg_addr = 8'h09;
    step();
    check_eq("dbg_wins", obs_dbg_gnt, 1);
    check_eq("dbg_blocks_if", obs_if_gnt, 0);
    dbg_req = 0;
    step();
    check_eq("if_after_dbg", obs_if_gnt, 1);
    idle_inputs();
`endif

    // reset while a fetch read is in flight
    if_req = 1; if_addr = 8'h03;
    step();
    check_eq("mid_rd_rvalid", if_rvalid, 1);
    d_req = 1; d_we = 1;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_rvalid", if_rvalid, 0);
    check_eq("mid_rst_if_gnt", if_gnt, 0);
    check_eq("mid_rst_d_gnt", d_gnt, 0);
    check_eq("mid_rst_w_en", ram_w_en, 0);
    @(posedge clk);
    #1;
    idle_inputs();
    rst_n = 1'b1;
    model_reset();

    for (int i = 0; i < 400; i++) begin
      if_req  = ($urandom % 4) != 0;
      if_addr = AW'($urandom % 16);
      d_req   = ($urandom % 3) != 0;
      d_we    = $urandom % 2;
      d_addr  = AW'($urandom % 16);
      d_wdata = DW'($urandom);
`ifdef RAM_ARB_DBG_PORT_EN
      dbg_req   = ($urandom % 8) == 0;
      dbg_we    = $urandom % 2;
      dbg_addr  = AW'($urandom % 16);
      dbg_wdata = DW'($urandom);
`endif
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
